// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// State encodings, the hard-wired zero register and default widths.
package regfile_wb_arbiter_pkg;

    localparam int               DATA_W_DEF = 32;
    localparam int               CNT_W      = 4;
    localparam logic [4:0]       REG_ZERO   = 5'd0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_mux2to1_5b.sv
// 5-bit 2:1 select for register addresses.
// Latency: combinational. Backpressure: none.
// s=0 picks d0, s=1 picks d1.
module mux2to1_5b (
    input  logic [4:0] d0,
    input  logic [4:0] d1,
    input  logic       s,
    output logic [4:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between WB (A, priority) and the long-latency path (B).
// Latency: grant in cycle N, registered wr_en/wr_addr/wr_data in cycle N+1.
// Backpressure: B waits on b_ready; after STARVE_LIMIT blocked cycles the pipeline is stalled one cycle for B.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [4:0]        a_dest,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [4:0]        b_dest,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              stall_pipe,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              a_write;
    logic              force_st;
    logic              grant_a;
    logic              grant_b;
    logic              wr_en_d;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign a_write    = a_req && (a_dest != REG_ZERO);
    assign force_st   = (state_q == ST_FORCE);
    assign stall_pipe = force_st;

    // In FORCE the pipeline is frozen, so A is ignored and re-presented next cycle.
    assign b_ready = !rst && b_valid && (force_st || !a_write);
    assign grant_b = b_ready;
    assign grant_a = a_write && !force_st;
    assign wr_en_d = grant_a || (grant_b && (b_dest != REG_ZERO));

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (b_valid && !b_ready) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc >= LIMIT) ? ST_FORCE : ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    mux2to1_5b u_addr_mux (
        .d0 (a_dest),
        .d1 (b_dest),
        .s  (grant_b),
        .y  (sel_addr)
    );

    assign sel_data = grant_b ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_en   <= wr_en_d;
            // Address/data hold their last value on idle cycles.
            if (wr_en_d) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

endmodule
